// File: rtl/track_sequencer.sv
// -----------------------------------------------------------------------------
// track_sequencer
// Multi-track note sequencer: TRACKS x NOTES words of {len, octave, pitch},
// a per-track length register, and a one-hot-free IDLE/LOAD/PLAY/DONE player
// that times each note as (len+1) units of (UNIT_TICKS >> tempo) clocks.
//
// Build option: define TRACK_SEQUENCER_LOOP_EN to make playback wrap from the
// last note back to slot 0 (done pulses once per pass) instead of stopping.
// -----------------------------------------------------------------------------
module track_sequencer #(
  parameter int UNIT_TICKS = 3125000,
  parameter int TRACKS     = 8,
  parameter int NOTES      = 16
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_field,
  input  logic [2:0] wr_track,
  input  logic [3:0] wr_index,
  input  logic [5:0] wr_pitch,
  input  logic [2:0] wr_len,
  input  logic       play_start,
  input  logic       play_stop,
  input  logic [2:0] play_track,
  input  logic [1:0] tempo,
  output logic [8:0] note_out,
  output logic       note_valid,
  output logic [3:0] note_index,
  output logic       playing,
  output logic       done,
  output logic [4:0] track_len
);

  // Tick counter width: wide enough to hold UNIT_TICKS itself.
  localparam int TW = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Note storage and per-track lengths
  logic [8:0]    r_mem [TRACKS][NOTES];
  logic [4:0]    r_len [TRACKS];

  // Player state
  state_t        r_state;
  logic [2:0]    r_track;
  logic [3:0]    r_index;
  logic [3:0]    r_units;
  logic [TW-1:0] r_ticks;
  logic [TW-1:0] r_reload;
  logic [8:0]    r_note_out;
  logic          r_note_valid;
  logic          r_playing;
  logic          r_done;

  // Combinational helpers
  logic [4:0]    w_wr_slot_len;
  logic [4:0]    w_sel_len;
  logic [8:0]    w_cur_word;
  logic [4:0]    w_cur_len;
  logic [TW-1:0] w_shifted;
  logic [TW-1:0] w_period;
  logic [TW-1:0] w_tick_reload;
  logic          w_last_note;
  logic          w_unit_last;
  logic          w_tick_zero;

  // Derive write length, read-out words, tick period and end-of-note flags
  always_comb begin
    w_wr_slot_len = {1'b0, wr_index} + 5'd1;
    w_sel_len     = r_len[play_track];
    w_cur_word    = r_mem[r_track][r_index];
    w_cur_len     = r_len[r_track];
    w_shifted     = TW'(UNIT_TICKS) >> tempo;
    // A very small UNIT_TICKS at fast tempo could shift to zero; never
    // let a unit be shorter than one clock.
    if (w_shifted == TW'(0)) begin
      w_period = TW'(1);
    end else begin
      w_period = w_shifted;
    end
    w_tick_reload = w_period - TW'(1);
    // ">=" also terminates cleanly if the track shrinks by reset-free means.
    w_last_note   = (({1'b0, r_index} + 5'd1) >= w_cur_len);
    w_unit_last   = (r_units == 4'd1);
    w_tick_zero   = (r_ticks == TW'(0));
  end

  // Storage write port: pitch writes grow the track length, length writes do not
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < TRACKS; t++) begin
        r_len[t] <= 5'd0;
        for (int n = 0; n < NOTES; n++) begin
          r_mem[t][n] <= 9'd0;
        end
      end
    end else if (wr_en) begin
      if (wr_field == 1'b0) begin
        r_mem[wr_track][wr_index][5:0] <= wr_pitch;
        if (w_wr_slot_len > r_len[wr_track]) begin
          r_len[wr_track] <= w_wr_slot_len;
        end else begin
          r_len[wr_track] <= r_len[wr_track];
        end
      end else begin
        r_mem[wr_track][wr_index][8:6] <= wr_len;
      end
    end else begin
      r_len <= r_len;
    end
  end

  // Playback state machine with registered outputs; stop overrides everything
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_track      <= 3'd0;
      r_index      <= 4'd0;
      r_units      <= 4'd0;
      r_ticks      <= TW'(0);
      r_reload     <= TW'(0);
      r_note_out   <= 9'd0;
      r_note_valid <= 1'b0;
      r_playing    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (play_stop) begin
        // Abort (or, in IDLE, suppress a simultaneous start) without done.
        r_state      <= S_IDLE;
        r_note_valid <= 1'b0;
        r_playing    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_note_valid <= 1'b0;
            if (play_start) begin
              r_track   <= play_track;
              r_index   <= 4'd0;
              r_playing <= 1'b1;
              if (w_sel_len != 5'd0) begin
                r_state <= S_LOAD;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end else begin
              r_playing <= 1'b0;
            end
          end

          S_LOAD: begin
            // Storage is read before this edge's write lands, so a colliding
            // write is seen only on the next pass.
            r_note_out   <= w_cur_word;
            r_units      <= {1'b0, w_cur_word[8:6]} + 4'd1;
            r_ticks      <= w_tick_reload;
            r_reload     <= w_tick_reload;
            r_note_valid <= 1'b1;
            r_playing    <= 1'b1;
            r_state      <= S_PLAY;
          end

          S_PLAY: begin
            if (w_tick_zero) begin
              r_ticks <= r_reload;
              r_units <= r_units - 4'd1;
              if (w_unit_last) begin
                r_note_valid <= 1'b0;
                if (w_last_note) begin
`ifdef TRACK_SEQUENCER_LOOP_EN
                  r_index <= 4'd0;
                  r_state <= S_LOAD;
                  r_done  <= 1'b1;
`else
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
`endif
                end else begin
                  r_index <= r_index + 4'd1;
                  r_state <= S_LOAD;
                end
              end else begin
                r_note_valid <= 1'b1;
              end
            end else begin
              r_ticks <= r_ticks - TW'(1);
            end
          end

          S_DONE: begin
            r_note_valid <= 1'b0;
            r_playing    <= 1'b0;
            r_state      <= S_IDLE;
          end

          default: begin
            r_note_valid <= 1'b0;
            r_playing    <= 1'b0;
            r_state      <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign note_out   = r_note_out;
  assign note_valid = r_note_valid;
  assign note_index = r_index;
  assign playing    = r_playing;
  assign done       = r_done;
  assign track_len  = w_sel_len;

endmodule
